// File: rtl/ext_mem_host.sv
// Host-side initiator for the CPU external memory ports.
// Loads IMEM/DMEM from a word stream, runs the CPU for a fixed number of
// cycles, and dumps DMEM back out one word at a time. Memory access and CPU
// execution never overlap because a single FSM owns every strobe.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | cmd_ready high, waiting for a command
// S_LOAD      | accepting din words, one write strobe per accepted word
// S_RUN       | cpu_enable high, counting down the run length
// S_DUMP_RD   | dmem_ren high for one cycle at the current word address
// S_DUMP_WAIT | waiting RD_LAT cycles from the read strobe for dmem_rdata
// S_DUMP_OUT  | dout_valid high, dout_data held until dout_ready
module ext_mem_host #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [31:0]      dout_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      imem_addr,
  output logic             imem_wen,
  output logic             imem_ren,
  output logic [31:0]      imem_wdata,
  output logic [31:0]      dmem_addr,
  output logic             dmem_wen,
  output logic             dmem_ren,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  output logic             cpu_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_OUT
  } state_t;

  // Latency counter only needs to hold RD_LAT-1.
  localparam int unsigned      LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      STEP     = 32'(ADDR_STEP);

  localparam logic [1:0] OP_LOAD_I = 2'd0;
  localparam logic [1:0] OP_LOAD_D = 2'd1;
  localparam logic [1:0] OP_RUN    = 2'd2;

  state_t           state;
  logic             op_dmem;   // load target: 1 = DMEM, 0 = IMEM
  logic [31:0]      addr_q;    // address of the next word to touch
  logic [CNT_W-1:0] remain_q;  // words (or run cycles) still to go
  logic [LAT_W-1:0] lat_q;     // read-latency down-counter

  // The host never reads instruction memory.
  assign imem_ren = 1'b0;

  // Command sequencer: owns every strobe so at most one is ever active.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= S_IDLE;
      op_dmem    <= 1'b0;
      addr_q     <= '0;
      remain_q   <= '0;
      lat_q      <= '0;
      cmd_ready  <= 1'b0;
      din_ready  <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      imem_addr  <= '0;
      imem_wen   <= 1'b0;
      imem_wdata <= '0;
      dmem_addr  <= '0;
      dmem_wen   <= 1'b0;
      dmem_ren   <= 1'b0;
      dmem_wdata <= '0;
      cpu_enable <= 1'b0;
    end else begin
      // Strobes and done are single-cycle unless re-asserted below.
      done     <= 1'b0;
      imem_wen <= 1'b0;
      dmem_wen <= 1'b0;
      dmem_ren <= 1'b0;

      if (busy && abort) begin
        // Abort wins over any handshake in the same cycle, so a word
        // accepted alongside abort never produces a write strobe.
        state      <= S_IDLE;
        busy       <= 1'b0;
        cmd_ready  <= 1'b1;
        din_ready  <= 1'b0;
        dout_valid <= 1'b0;
        cpu_enable <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              addr_q   <= cmd_base;
              remain_q <= cmd_count;
              op_dmem  <= (cmd_op == OP_LOAD_D);
              if (cmd_count == '0) begin
                // Empty command: acknowledge without touching the bus.
                done <= 1'b1;
              end else begin
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
                case (cmd_op)
                  OP_LOAD_I, OP_LOAD_D: begin
                    state     <= S_LOAD;
                    din_ready <= 1'b1;
                  end
                  OP_RUN: begin
                    state      <= S_RUN;
                    cpu_enable <= 1'b1;
                  end
                  default: begin
                    state     <= S_DUMP_RD;
                    dmem_ren  <= 1'b1;
                    dmem_addr <= cmd_base;
                  end
                endcase
              end
            end
          end

          S_LOAD: begin
            if (din_valid && din_ready) begin
              addr_q   <= addr_q + STEP;
              remain_q <= remain_q - CNT_ONE;
              if (op_dmem) begin
                dmem_wen   <= 1'b1;
                dmem_addr  <= addr_q;
                dmem_wdata <= din_data;
              end else begin
                imem_wen   <= 1'b1;
                imem_addr  <= addr_q;
                imem_wdata <= din_data;
              end
              if (remain_q == CNT_ONE) begin
                // done lines up with the final write strobe.
                din_ready <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end
            end
          end

          S_RUN: begin
            if (remain_q == CNT_ONE) begin
              cpu_enable <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              cmd_ready  <= 1'b1;
              state      <= S_IDLE;
            end else begin
              remain_q <= remain_q - CNT_ONE;
            end
          end

          S_DUMP_RD: begin
            // dmem_ren was raised on entry; it drops here automatically.
            addr_q <= addr_q + STEP;
            lat_q  <= LAT_INIT;
            state  <= S_DUMP_WAIT;
          end

          S_DUMP_WAIT: begin
            if (lat_q == '0) begin
              dout_data  <= dmem_rdata;
              dout_valid <= 1'b1;
              state      <= S_DUMP_OUT;
            end else begin
              lat_q <= lat_q - LAT_ONE;
            end
          end

          S_DUMP_OUT: begin
            if (dout_ready) begin
              dout_valid <= 1'b0;
              remain_q   <= remain_q - CNT_ONE;
              if (remain_q == CNT_ONE) begin
                done      <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end else begin
                dmem_ren  <= 1'b1;
                dmem_addr <= addr_q;
                state     <= S_DUMP_RD;
              end
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_host.sv
module tb_ext_mem_host;

  logic        clk;
  logic        arst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_base;
  logic [15:0] cmd_count;
  logic        abort;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        busy;
  logic        done;
  logic [31:0] imem_addr;
  logic        imem_wen;
  logic        imem_ren;
  logic [31:0] imem_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic        dmem_ren;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        cpu_enable;

  ext_mem_host #(.ADDR_STEP(4), .CNT_W(16), .RD_LAT(1)) dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .abort(abort),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .busy(busy), .done(done),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren),
    .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .cpu_enable(cpu_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU data memory as seen through the external port (1-cycle read latency).
  logic [31:0] cpu_dmem [logic [31:0]];
  initial dmem_rdata = 32'h0;
  always @(posedge clk) begin
    if (dmem_ren) dmem_rdata <= cpu_dmem.exists(dmem_addr) ? cpu_dmem[dmem_addr] : 32'h0;
    if (dmem_wen) cpu_dmem[dmem_addr] = dmem_wdata;
  end

  // Reference model: what DMEM should contain after the loads the bench issued.
  logic [31:0] ref_dmem [logic [31:0]];

  // Bus monitor: logs every strobe with its cycle number.
  typedef struct { int c; logic [31:0] a; logic [31:0] d; } ev_t;
  ev_t iw_q[$];
  ev_t dw_q[$];
  ev_t rd_q[$];
  int  done_q[$];
  int  en_q[$];
  int  inv_viol = 0;

  always @(negedge clk) begin
    if (!arst) begin
      if (imem_wen)   iw_q.push_back('{c: cyc, a: imem_addr, d: imem_wdata});
      if (dmem_wen)   dw_q.push_back('{c: cyc, a: dmem_addr, d: dmem_wdata});
      if (dmem_ren)   rd_q.push_back('{c: cyc, a: dmem_addr, d: 32'h0});
      if (done)       done_q.push_back(cyc);
      if (cpu_enable) en_q.push_back(cyc);
      if (int'(imem_wen) + int'(dmem_wen) + int'(dmem_ren) > 1) inv_viol++;
      if (cmd_ready && busy) inv_viol++;
      if (imem_ren) inv_viol++;
      if (cpu_enable && (imem_wen || dmem_wen || dmem_ren)) inv_viol++;
    end
  end

  // Stimulus buffers shared by the driver tasks.
  logic [31:0] wbuf [16];
  int          gbuf [16];
  int          stall_s [16];
  logic [31:0] dump_got [16];
  int          got_n;
  int          hs_cyc;
  int          stable_err;
  int          cmd_hs_cyc;

  task automatic clear_logs();
    iw_q.delete(); dw_q.delete(); rd_q.delete(); done_q.delete(); en_q.delete();
    inv_viol = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] base, input logic [15:0] cnt);
    int t;
    cmd_op = op; cmd_base = base; cmd_count = cnt; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_hs_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drive_load(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      din_valid = 1'b0;
      repeat (gbuf[k]) @(negedge clk);
      din_valid = 1'b1;
      din_data  = wbuf[k];
      t = 0;
      while (!din_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!din_ready) begin
        checks++; errors++;
        $display("FAIL din_accept_timeout: word %0d din_ready=%b required 1", k, din_ready);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic collect_dump(input int n);
    logic        held;
    logic [31:0] held_data;
    int          stalled;
    got_n = 0; stable_err = 0; held = 1'b0; held_data = 32'h0; stalled = 0;
    for (int t = 0; t < 400 && got_n < n; t++) begin
      if (held && (!dout_valid || dout_data !== held_data)) stable_err++;
      if (dout_valid) begin
        if (stalled < stall_s[got_n]) begin
          dout_ready = 1'b0; stalled++; held = 1'b1; held_data = dout_data;
        end else begin
          dout_ready = 1'b1; dump_got[got_n] = dout_data; got_n++;
          hs_cyc = cyc; held = 1'b0; stalled = 0;
        end
      end else begin
        dout_ready = 1'b0;
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [231:0] outs;
    arst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {cmd_ready, din_ready, dout_valid, dout_data, busy, done, imem_addr, imem_wen,
              imem_ren, imem_wdata, dmem_addr, dmem_wen, dmem_ren, dmem_wdata, cpu_enable, 32'h0, 15'h0};
      checks++;
      if (outs !== '0) begin
        errors++; $display("FAIL reset_outputs: got %h required 0", outs);
      end
    end
    arst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready_early: cmd_ready=%b required 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || cpu_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b en=%b required 1 0 0", cmd_ready, busy, cpu_enable);
    end
  endtask

  task automatic test_load_imem();
    clear_logs();
    wbuf[0] = 32'h20080005; wbuf[1] = 32'h20090007; wbuf[2] = 32'h01095020;
    gbuf[0] = 0; gbuf[1] = 2; gbuf[2] = 0;
    send_cmd(2'd0, 32'h0, 16'd3);
    drive_load(3);
    repeat (4) @(negedge clk);
    checks++;
    if (iw_q.size() !== 3) begin
      errors++; $display("FAIL imem_wen_count: got %0d required 3", iw_q.size());
    end
    for (int k = 0; k < 3 && k < iw_q.size(); k++) begin
      checks++;
      if (iw_q[k].a !== 32'(k * 4) || iw_q[k].d !== wbuf[k]) begin
        errors++;
        $display("FAIL imem_write%0d: got %h/%h required %h/%h", k, iw_q[k].a, iw_q[k].d, 32'(k * 4), wbuf[k]);
      end
    end
    checks++;
    if (dw_q.size() !== 0 || rd_q.size() !== 0) begin
      errors++; $display("FAIL imem_load_dmem_quiet: dmem strobes %0d required 0", dw_q.size() + rd_q.size());
    end
    checks++;
    if (done_q.size() !== 1 || iw_q.size() !== 3 || done_q[0] !== iw_q[2].c) begin
      errors++; $display("FAIL imem_done_timing: done pulses %0d, required one with last write", done_q.size());
    end
    checks++;
    if (inv_viol !== 0) begin
      errors++; $display("FAIL imem_invariants: got %0d violations required 0", inv_viol);
    end
  endtask

  task automatic test_load_dump();
    clear_logs();
    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'h12345678; gbuf[0] = 0; gbuf[1] = 0;
    send_cmd(2'd1, 32'h100, 16'd2);
    drive_load(2);
    repeat (4) @(negedge clk);
    ref_dmem[32'h100] = 32'hDEADBEEF;
    ref_dmem[32'h104] = 32'h12345678;
    checks++;
    if (dw_q.size() !== 2 || dw_q[0].a !== 32'h100 || dw_q[1].a !== 32'h104 ||
        dw_q[0].d !== 32'hDEADBEEF || dw_q[1].d !== 32'h12345678) begin
      errors++; $display("FAIL dmem_load: got %0d writes, required 2 at 0x100/0x104", dw_q.size());
    end
    clear_logs();
    stall_s[0] = 4; stall_s[1] = 0;
    send_cmd(2'd3, 32'h100, 16'd2);
    collect_dump(2);
    repeat (3) @(negedge clk);
    checks++;
    if (got_n !== 2 || dump_got[0] !== 32'hDEADBEEF || dump_got[1] !== 32'h12345678) begin
      errors++;
      $display("FAIL dump_data: got n=%0d %h %h required 2 deadbeef 12345678", got_n, dump_got[0], dump_got[1]);
    end
    checks++;
    if (stable_err !== 0) begin
      errors++; $display("FAIL dump_stall_stable: got %0d changes required 0", stable_err);
    end
    checks++;
    if (rd_q.size() !== 2 || rd_q[0].a !== 32'h100 || rd_q[1].a !== 32'h104) begin
      errors++; $display("FAIL dump_ren: got %0d reads required 2 at 0x100/0x104", rd_q.size());
    end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== hs_cyc + 1) begin
      errors++; $display("FAIL dump_done: got %0d pulses required 1 at cycle %0d", done_q.size(), hs_cyc + 1);
    end
    checks++;
    if (inv_viol !== 0 || dw_q.size() !== 0 || iw_q.size() !== 0) begin
      errors++; $display("FAIL dump_invariants: got %0d violations required 0", inv_viol);
    end
  endtask

  task automatic check_run(input int rc);
    clear_logs();
    send_cmd(2'd2, $urandom, 16'(rc));
    repeat (rc + 4) @(negedge clk);
    checks++;
    if (en_q.size() !== rc || en_q[en_q.size() - 1] - en_q[0] !== rc - 1) begin
      errors++; $display("FAIL run_enable_cycles: got %0d required %0d consecutive", en_q.size(), rc);
    end
    checks++;
    if (done_q.size() !== 1 || en_q.size() === 0 || done_q[0] !== en_q[en_q.size() - 1] + 1) begin
      errors++; $display("FAIL run_done: got %0d pulses required 1 right after enable", done_q.size());
    end
    checks++;
    if (iw_q.size() + dw_q.size() + rd_q.size() !== 0 || inv_viol !== 0) begin
      errors++; $display("FAIL run_quiet_bus: got %0d strobes required 0", iw_q.size() + dw_q.size() + rd_q.size());
    end
  endtask

  task automatic test_run();
    check_run(5);
  endtask

  task automatic test_zero_and_abort();
    clear_logs();
    send_cmd(2'd0, 32'h40, 16'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== cmd_hs_cyc + 1 || iw_q.size() !== 0) begin
      errors++; $display("FAIL zero_count: got %0d done %0d wen required 1 done 0 wen", done_q.size(), iw_q.size());
    end
    clear_logs();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_abort: ready=%b done=%b busy=%b required 1 0 0", cmd_ready, done, busy);
    end
    wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1; gbuf[0] = 0; gbuf[1] = 1;
    send_cmd(2'd1, 32'h200, 16'd4);
    drive_load(2);
    din_valid = 1'b1; din_data = 32'hC2C2C2C2; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; din_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++; $display("FAIL abort_next_cycle: ready=%b busy=%b din_ready=%b required 1 0 0", cmd_ready, busy, din_ready);
    end
    repeat (3) @(negedge clk);
    ref_dmem[32'h200] = 32'hA0A0A0A0;
    ref_dmem[32'h204] = 32'hB1B1B1B1;
    checks++;
    if (dw_q.size() !== 2 || dw_q[0].a !== 32'h200 || dw_q[1].a !== 32'h204) begin
      errors++; $display("FAIL abort_writes: got %0d dmem_wen required 2", dw_q.size());
    end
    checks++;
    if (done_q.size() !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d pulses required 0", done_q.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    int nren;
    clear_logs();
    wbuf[0] = 32'h11110000; wbuf[1] = 32'h22220000; wbuf[2] = 32'h33330000;
    gbuf[0] = 0; gbuf[1] = 0; gbuf[2] = 0;
    send_cmd(2'd1, 32'h300, 16'd3);
    drive_load(3);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) ref_dmem[32'h300 + 32'(k * 4)] = wbuf[k];
    dout_ready = 1'b1;
    send_cmd(2'd3, 32'h300, 16'd3);
    nren = 0;
    for (int t = 0; t < 40; t++) begin
      if (dmem_ren) nren++;
      if (nren == 2) break;
      @(negedge clk);
    end
    checks++;
    if (nren !== 2) begin
      errors++; $display("FAIL mid_dump_second_read: got %0d reads required 2", nren);
    end
    @(negedge clk);
    arst = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dmem_ren !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dump: valid=%b ren=%b busy=%b ready=%b required 0 0 0 0", dout_valid, dmem_ren, busy, cmd_ready);
    end
    @(negedge clk);
    arst = 1'b0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    stall_s[0] = 1; stall_s[1] = 0;
    send_cmd(2'd3, 32'h200, 16'd2);
    collect_dump(2);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() !== 2 || rd_q[0].a !== 32'h200 || rd_q[1].a !== 32'h204) begin
      errors++; $display("FAIL post_reset_dump_addr: got %0d reads required 2 at 0x200/0x204", rd_q.size());
    end
    checks++;
    if (got_n !== 2 || dump_got[0] !== ref_dmem[32'h200] || dump_got[1] !== ref_dmem[32'h204]) begin
      errors++;
      $display("FAIL post_reset_dump_data: got %h %h required %h %h", dump_got[0], dump_got[1], ref_dmem[32'h200], ref_dmem[32'h204]);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    logic [31:0] ea;
    int n;
    int bad;
    for (int it = 0; it < 5; it++) begin
      base = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        wbuf[k] = $urandom; gbuf[k] = $urandom_range(0, 2); stall_s[k] = $urandom_range(0, 3);
      end
      clear_logs();
      send_cmd(2'd1, base, 16'(n));
      drive_load(n);
      repeat (4) @(negedge clk);
      bad = 0;
      for (int k = 0; k < n; k++) begin
        ea = base + 32'(k * 4);
        ref_dmem[ea] = wbuf[k];
        if (k >= dw_q.size() || dw_q[k].a !== ea || dw_q[k].d !== wbuf[k]) bad++;
      end
      checks++;
      if (dw_q.size() !== n || bad !== 0) begin
        errors++; $display("FAIL rand_load%0d: got %0d writes %0d bad required %0d 0", it, dw_q.size(), bad, n);
      end
      checks++;
      if (done_q.size() !== 1 || dw_q.size() === 0 || done_q[0] !== dw_q[dw_q.size() - 1].c) begin
        errors++; $display("FAIL rand_load_done%0d: got %0d pulses required 1 with last write", it, done_q.size());
      end
      clear_logs();
      send_cmd(2'd3, base, 16'(n));
      collect_dump(n);
      repeat (3) @(negedge clk);
      bad = 0;
      for (int k = 0; k < n; k++) begin
        ea = base + 32'(k * 4);
        if (k >= got_n || dump_got[k] !== ref_dmem[ea]) bad++;
        if (k >= rd_q.size() || rd_q[k].a !== ea) bad++;
      end
      checks++;
      if (got_n !== n || rd_q.size() !== n || bad !== 0 || stable_err !== 0) begin
        errors++;
        $display("FAIL rand_dump%0d: got n=%0d reads=%0d bad=%0d unstable=%0d required %0d %0d 0 0", it, got_n, rd_q.size(), bad, stable_err, n, n);
      end
      checks++;
      if (done_q.size() !== 1 || done_q[0] !== hs_cyc + 1 || inv_viol !== 0) begin
        errors++; $display("FAIL rand_dump_done%0d: got %0d pulses %0d violations required 1 0", it, done_q.size(), inv_viol);
      end
      check_run($urandom_range(1, 12));
    end
  endtask

  initial begin
    arst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_base = 32'h0; cmd_count = 16'h0;
    abort = 1'b0; din_valid = 1'b0; din_data = 32'h0; dout_ready = 1'b0;
    test_reset();
    test_load_imem();
    test_load_dump();
    test_run();
    test_zero_and_abort();
    test_reset_mid_dump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
